n64_pi_target: RTL and testbench

Parametrised N64 cartridge-bus (PI) target: latches the multiplexed address from `AD` on ALE_H/ALE_L, auto-increments it across burst reads and writes, fetches read data from a backing memory over a req/ack handshake, and reports write beats to the fabric. It replaces the fixed 32-bit, read-only address latch and sits between the cartridge edge pins and the ROM/SRAM controllers.

---
 rtl/n64_pi_target_if.sv | 14 +
 rtl/n64_pi_target.sv | 143 ++++++++++++++
 tb/tb_n64_pi_target.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/n64_pi_target_if.sv
// n64_pi_target_if: fabric-side bundle of the N64 PI target.
// master (target side): drives mem_req/mem_addr fetch requests and wr_valid/wr_addr/wr_data write beats.
// slave (fabric side): answers fetches with one-cycle mem_ack plus mem_rdata.
interface n64_pi_target_if #(parameter int ADDR_W = 32);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    modport master (output mem_req, mem_addr, wr_valid, wr_addr, wr_data, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_addr, wr_valid, wr_addr, wr_data, output mem_ack, mem_rdata);
endinterface

// File: rtl/n64_pi_target.sv
// n64_pi_target: N64 cartridge-bus (PI) target with address latch, burst auto-increment, read fetch and write beats.
// Ports: clk, rst_n (async active-low); AD (muxed addr/data, inout); READ/WRITE (active-low strobes);
// ALE_H/ALE_L (address latch enables); bus (fetch req/ack and write beats); addr/addr_ready/hit status;
// err_underrun (read strobe with no valid data). Define N64_PI_PREFETCH_EN to fetch ahead of the read strobe.
module n64_pi_target #(
    parameter int          SYNC_STAGES = 2,
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hF000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [15:0]       AD,
    input  logic              READ,
    input  logic              WRITE,
    input  logic              ALE_H,
    input  logic              ALE_L,
    n64_pi_target_if.master   bus,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_ready,
    output logic              hit,
    output logic              err_underrun
);
    typedef enum logic [1:0] {IDLE, ADDR_HI, ADDR_LO, ACTIVE} state_t;
    localparam logic [ADDR_W-1:0] BASE = ADDR_BASE[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] MASK = ADDR_MASK[ADDR_W-1:0];
    state_t                    state;
    logic [SYNC_STAGES:0][3:0] sync;
    logic [3:0]                cur, prev;
    logic                      ale_h_rise, ale_h_fall, ale_l_fall, rd_rise, rd_fall, wr_rise;
    logic                      act, lo_done, trig, inval, ad_oe, buf_valid, pend, discard;
    logic [15:0]               buf_data;
    logic [ADDR_W-1:0]         inc_addr, lo_addr, trig_addr;

    function automatic logic dec(input logic [ADDR_W-1:0] a);
        return (a & MASK) == BASE;
    endfunction

    // strobe bit order {ALE_H, ALE_L, WRITE, READ}; edges come from the last sync stage and the history flop
    assign cur        = sync[SYNC_STAGES-1];
    assign prev       = sync[SYNC_STAGES];
    assign ale_h_rise = cur[3] & ~prev[3];
    assign ale_h_fall = ~cur[3] & prev[3];
    assign ale_l_fall = ~cur[2] & prev[2];
    assign wr_rise    = cur[1] & ~prev[1];
    assign rd_rise    = cur[0] & ~prev[0];
    assign rd_fall    = ~cur[0] & prev[0];
    assign inc_addr   = addr + ADDR_W'(2);
    assign lo_addr    = {addr[ADDR_W-1:16], AD[15:1], 1'b0};
    assign hit        = dec(addr);
    assign act        = state == ACTIVE && !ale_h_rise;
    assign lo_done    = state == ADDR_LO && ale_l_fall && !ale_h_rise;
    // a read rise consumes the buffer; ALE_H redirects the burst
    assign inval      = ale_h_rise || (state == ACTIVE && rd_rise);
`ifdef N64_PI_PREFETCH_EN
    assign trig         = (lo_done && dec(lo_addr)) || (act && rd_rise && dec(inc_addr));
    assign trig_addr    = lo_done ? lo_addr : inc_addr;
    assign ad_oe        = state == ACTIVE && hit && !cur[0] && cur[1];
`else
    assign trig         = act && rd_fall && hit;
    assign trig_addr    = addr;
    assign ad_oe        = state == ACTIVE && hit && !cur[0] && cur[1] && buf_valid;
    assign err_underrun = 1'b0;
`endif
    assign AD = ad_oe ? buf_data : 16'hzzzz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync         <= {(SYNC_STAGES+1){4'b0011}};
            state        <= IDLE;
            addr         <= '0;
            addr_ready   <= 1'b0;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
            bus.wr_valid <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            buf_data     <= '0;
            buf_valid    <= 1'b0;
            pend         <= 1'b0;
            discard      <= 1'b0;
`ifdef N64_PI_PREFETCH_EN
            err_underrun <= 1'b0;
`endif
        end else begin
            sync         <= {sync[SYNC_STAGES-1:0], {ALE_H, ALE_L, WRITE, READ}};
            bus.wr_valid <= 1'b0;
`ifdef N64_PI_PREFETCH_EN
            err_underrun <= act && rd_fall && hit && !buf_valid;
`endif
            if (bus.mem_req && bus.mem_ack) begin
                bus.mem_req <= 1'b0;
                discard     <= 1'b0;
                if (!discard) begin
                    buf_data  <= bus.mem_rdata;
                    buf_valid <= 1'b1;
                end
            end
            // single outstanding request: a trigger while busy is parked and reissued at the current address
            if ((trig || pend) && !ale_h_rise) begin
                if (!bus.mem_req) begin
                    bus.mem_req  <= 1'b1;
                    bus.mem_addr <= trig ? trig_addr : addr;
                    pend         <= 1'b0;
                end else
                    pend <= 1'b1;
            end
            if (inval) begin
                buf_valid <= 1'b0;
                if (bus.mem_req && !bus.mem_ack)
                    discard <= 1'b1;
            end
            if (ale_h_rise) begin
                state      <= ADDR_HI;
                addr_ready <= 1'b0;
                pend       <= 1'b0;
            end else begin
                case (state)
                    ADDR_HI: if (ale_h_fall) begin
                        addr[ADDR_W-1:16] <= AD[ADDR_W-17:0];
                        state             <= ADDR_LO;
                    end
                    ADDR_LO: if (ale_l_fall) begin
                        addr       <= lo_addr;
                        state      <= ACTIVE;
                        addr_ready <= 1'b1;
                    end
                    ACTIVE: if (rd_rise)
                        addr <= inc_addr;
                    else if (wr_rise) begin
                        bus.wr_valid <= hit;
                        if (hit) begin
                            bus.wr_addr <= addr;
                            bus.wr_data <= AD;
                        end
                        addr <= inc_addr;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_n64_pi_target.sv
// tb_n64_pi_target: randomized scoreboard bench for n64_pi_target against a transaction-level bus model.
`timescale 1ns/1ps
module tb_n64_pi_target;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] MASK = 32'hF000_0000;
`ifdef N64_PI_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        rd_n = 1'b1, wr_n = 1'b1, ale_h = 1'b0, ale_l = 1'b0;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_ad = 16'h0;
    wire  [15:0] ad;
    logic [31:0] addr;
    logic        addr_ready, hit, err_underrun;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] mem_q[$];
    logic [47:0] wr_q[$];
    logic [15:0] rd_q[$];
    int          err_pend = 0;
    logic        hold_ack = 1'b0, rd_chk = 1'b1;
    int          lat = 1;

    assign ad = tb_oe ? tb_ad : 16'hzzzz;
    n64_pi_target_if #(.ADDR_W(32)) bus();
    n64_pi_target dut (
        .clk(clk), .rst_n(rst_n), .AD(ad), .READ(rd_n), .WRITE(wr_n), .ALE_H(ale_h), .ALE_L(ale_l),
        .bus(bus), .addr(addr), .addr_ready(addr_ready), .hit(hit), .err_underrun(err_underrun)
    );
    always #5 clk = ~clk;

    function automatic logic is_hit(input logic [31:0] a);
        return (a & MASK) == BASE;
    endfunction
    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[16:1] ^ a[31:16] ^ 16'h5A5A;
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // fabric memory: acknowledges each request after a random latency unless held
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (bus.mem_req && !hold_ack) begin
                if (lat == 0) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                    lat           = $urandom_range(0, 3);
                end else
                    lat--;
            end
        end
    end

    // monitor: pops expected responses whenever the DUT presents a request, beat, read data or error
    initial begin
        logic        req_d = 1'b0, oe_d = 1'b0;
        logic [47:0] w;
        forever begin
            @(negedge clk);
            if (bus.mem_req && !req_d) begin
                if (mem_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL mem_req: unexpected request addr %h, expected none", bus.mem_addr);
                end else
                    check("mem_addr", bus.mem_addr, mem_q.pop_front());
            end
            if (bus.wr_valid) begin
                if (wr_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL wr_valid: unexpected beat addr %h data %h, expected none", bus.wr_addr, bus.wr_data);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", bus.wr_addr, w[47:16]);
                    check("wr_data", 32'(bus.wr_data), 32'(w[15:0]));
                end
            end
            if (rd_chk && dut.ad_oe && !oe_d) begin
                if (rd_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL ad_drive: unexpected drive %h, expected Z", ad);
                end else
                    check("ad_rdata", 32'(ad), 32'(rd_q.pop_front()));
            end
            if (err_underrun) begin
                check("err_underrun_expected", 32'(err_pend > 0), 32'd1);
                if (err_pend > 0) err_pend--;
            end
            req_d = bus.mem_req;
            oe_d  = dut.ad_oe;
        end
    end

    task automatic latch(input logic [31:0] a);
        ale_h = 1'b1; ale_l = 1'b1; cyc(6);
        rd_n = 1'b1; tb_oe = 1'b1; tb_ad = a[31:16]; cyc(6);
        ale_h = 1'b0; cyc(6);
        tb_ad = a[15:0]; cyc(2);
        m_addr = {a[31:1], 1'b0};
        if (PF && is_hit(m_addr)) mem_q.push_back(m_addr);
        ale_l = 1'b0; cyc(6);
        tb_oe = 1'b0;
    endtask
    task automatic do_read();
        logic h;
        h = is_hit(m_addr);
        if (h) begin
            if (!PF) mem_q.push_back(m_addr);
            rd_q.push_back(mem_word(m_addr));
        end
        cyc(4); rd_n = 1'b0; cyc(14);
        if (!h) check("ad_z_on_miss", 32'(dut.ad_oe), 32'd0);
        rd_n = 1'b1;
        m_addr += 32'd2;
        if (PF && is_hit(m_addr)) mem_q.push_back(m_addr);
        cyc(10);
    endtask
    task automatic do_write(input logic [15:0] d);
        if (is_hit(m_addr)) wr_q.push_back({m_addr, d});
        tb_oe = 1'b1; tb_ad = d; cyc(2);
        wr_n = 1'b0; cyc(6);
        wr_n = 1'b1; cyc(6);
        tb_oe = 1'b0;
        m_addr += 32'd2;
        cyc(2);
    endtask
    task automatic check_status(input string name);
        check({name, "_addr"}, addr, m_addr);
        check({name, "_ready"}, 32'(addr_ready), 32'd1);
        check({name, "_hit"}, 32'(hit), 32'(is_hit(m_addr)));
    endtask
    task automatic check_reset(input string name);
        check({name, "_addr"}, addr, 32'h0);
        check({name, "_ready"}, 32'(addr_ready), 32'd0);
        check({name, "_hit"}, 32'(hit), 32'd0);
        check({name, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        check({name, "_mem_addr"}, bus.mem_addr, 32'h0);
        check({name, "_wr_valid"}, 32'(bus.wr_valid), 32'd0);
        check({name, "_wr_addr"}, bus.wr_addr, 32'h0);
        check({name, "_wr_data"}, 32'(bus.wr_data), 32'd0);
        check({name, "_err"}, 32'(err_underrun), 32'd0);
        check({name, "_ad_oe"}, 32'(dut.ad_oe), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        cyc(3);
        check_reset("reset");
        rst_n = 1'b1;
        cyc(3);
        latch(32'h1000_0041);
        check("latch_addr", addr, 32'h1000_0040);
        check_status("latch");
        for (int i = 0; i < 4; i++) do_read();
        check("burst_addr", addr, 32'h1000_0048);
        latch(32'h2000_0000);
        check("miss_hit", 32'(hit), 32'd0);
        do_read();
        do_write(16'hBEEF);
        check("miss_addr", addr, 32'h2000_0004);
        latch(32'h1000_0010);
        do_write(16'hBEEF);
        check_status("write");
        latch(32'hFFFF_FFFE);
        do_read();
        check("wrap_addr", addr, 32'h0000_0000);
        // held fetch redirected by a new address: late data must be dropped
        if (PF) hold_ack = 1'b1;
        latch(32'h1000_0100);
        hold_ack = 1'b1;
        if (!PF) mem_q.push_back(m_addr);
`ifdef N64_PI_PREFETCH_EN
        rd_chk = 1'b0;
        err_pend = 1;
`endif
        rd_n = 1'b0; cyc(8);
`ifndef N64_PI_PREFETCH_EN
        check("ad_z_no_data", 32'(dut.ad_oe), 32'd0);
`endif
        latch(32'h1000_0300);
        hold_ack = 1'b0;
        cyc(12);
        rd_chk = 1'b1;
        check("err_seen", 32'(err_pend), 32'd0);
        do_read();
        check_status("redirect");
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            a = ($urandom_range(0, 2) != 0) ? ((a & ~MASK) | BASE) : (is_hit(a) ? a ^ 32'h4000_0000 : a);
            latch(a);
            check_status("rand_latch");
            for (int r = $urandom_range(0, 3); r > 0; r--) do_read();
            for (int w = $urandom_range(0, 2); w > 0; w--) do_write(16'($urandom));
            check_status("rand_burst");
        end
        // reset while the DUT drives AD
        latch(32'h1000_0200);
        if (!PF) mem_q.push_back(m_addr);
        rd_q.push_back(mem_word(m_addr));
        rd_n = 1'b0; cyc(14);
        check("pre_reset_oe", 32'(dut.ad_oe), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        rd_n = 1'b1;
        cyc(4);
        rst_n = 1'b1;
        cyc(5);
        check("mem_q_left", 32'(mem_q.size()), 32'd0);
        check("wr_q_left", 32'(wr_q.size()), 32'd0);
        check("rd_q_left", 32'(rd_q.size()), 32'd0);
        check("err_left", 32'(err_pend), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
